// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element sequencer: state encodings
// and the default counter width.
package pe_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pe_sequencer_if.sv
// Handshake bundle between the PE sequencer, its job requester and the
// ifmap/filter/psum buffer instances. The sequencer only sees valid/ready flags.
interface pe_sequencer_if
  import pe_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             start;
  logic [CNT_W-1:0] filt_len;
  logic [CNT_W-1:0] num_out;
  logic             ifmap_valid;
  logic             ifmap_read_en;
  logic             filt_valid;
  logic             filt_read_en;
  logic             mac_en;
  logic             acc_clr;
  logic             psum_ready;
  logic             psum_write_en;
  logic             busy;
  logic             done;

  modport master (
    input  start, filt_len, num_out, ifmap_valid, filt_valid, psum_ready,
    output ifmap_read_en, filt_read_en, mac_en, acc_clr, psum_write_en, busy, done
  );

  modport slave (
    output start, filt_len, num_out, ifmap_valid, filt_valid, psum_ready,
    input  ifmap_read_en, filt_read_en, mac_en, acc_clr, psum_write_en, busy, done
  );

endinterface

// File: rtl/pe_seq_counter.sv
// Up-counter with synchronous clear and a flag raised when the count equals
// limit-1 (wrapping in CNT_W bits).
module pe_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == (limit - CNT_W'(1)));

endmodule

// File: rtl/pe_sequencer.sv
// Control FSM for one CNN processing element: pops ifmap/filter buffers in
// lockstep, strobes the MAC, and pushes each finished partial sum.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  pe_sequencer_if.master bus
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] filt_len_reg, num_out_reg;
  logic [CNT_W-1:0] k_count, o_idx_unused;
  logic             k_last, o_last;
  logic             accept, beat, push, zero_cfg;

  assign accept   = (state_reg == ST_IDLE) && bus.start;
  assign beat     = (state_reg == ST_MAC) && bus.ifmap_valid && bus.filt_valid;
  assign push     = (state_reg == ST_WRITE) && bus.psum_ready;
  assign zero_cfg = (bus.filt_len == '0) || (bus.num_out == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_len_reg <= '0;
      num_out_reg  <= '0;
    end else if (accept) begin
      filt_len_reg <= bus.filt_len;
      num_out_reg  <= bus.num_out;
    end
  end

  // k wraps to 0 on the closing beat of a window so the next window opens with acc_clr
  pe_seq_counter #(.CNT_W(CNT_W)) u_k_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (beat),
    .clr   (accept || (beat && k_last)),
    .limit (filt_len_reg),
    .count (k_count),
    .last  (k_last)
  );

  pe_seq_counter #(.CNT_W(CNT_W)) u_o_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (push),
    .clr   (accept),
    .limit (num_out_reg),
    .count (o_idx_unused),
    .last  (o_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = zero_cfg ? ST_DONE : ST_MAC;
        end
      end
      ST_MAC: begin
        if (beat && k_last) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.psum_ready) begin
          state_next = o_last ? ST_DONE : ST_MAC;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are Mealy so a pop/push lands in the same cycle the buffer flag is seen
  always_comb begin
    bus.ifmap_read_en = 1'b0;
    bus.filt_read_en  = 1'b0;
    bus.mac_en        = 1'b0;
    bus.acc_clr       = 1'b0;
    bus.psum_write_en = 1'b0;
    bus.busy          = (state_reg != ST_IDLE);
    bus.done          = (state_reg == ST_DONE);
    case (state_reg)
      ST_MAC: begin
        bus.ifmap_read_en = beat;
        bus.filt_read_en  = beat;
        bus.mac_en        = beat;
        bus.acc_clr       = beat && (k_count == '0);
      end
      ST_WRITE: bus.psum_write_en = bus.psum_ready;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: table of job scenarios with
// hand-computed beat/clear/write counts and latencies, plus a mid-job reset.
module tb_pe_sequencer;
  import pe_pkg::*;

  localparam int CNT_W  = DEFAULT_CNT_W;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

  pe_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    string       name;
    int          fl;
    int          no;
    int          stall_after;
    int          stall_len;
    int          bp_after;
    int          bp_len;
    int          mid_start;
    int          pre_reset;
    int          exp_beats;
    int          exp_clrs;
    logic [31:0] exp_mask;
    int          exp_writes;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  int          beats, clrs, writes, ifpops, fpops, lat, anomalies, bp_reads;
  logic [31:0] clr_mask;
  bit          bp_push;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {bus_if.ifmap_read_en, bus_if.filt_read_en, bus_if.mac_en, bus_if.acc_clr,
            bus_if.psum_write_en, bus_if.busy, bus_if.done};
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_job(input vec_t v);
    int stall_left, bp_left;
    bit stall_done, bp_done, in_bp, pending_after, first_after_bp;
    stall_left = 0; bp_left = 0; stall_done = 0; bp_done = 0;
    in_bp = 0; pending_after = 0; first_after_bp = 0;
    beats = 0; clrs = 0; writes = 0; ifpops = 0; fpops = 0;
    anomalies = 0; bp_reads = 0; bp_push = 0; clr_mask = '0; lat = -1;

    bus_if.start       = 1'b1;
    bus_if.filt_len    = CNT_W'(v.fl);
    bus_if.num_out     = CNT_W'(v.no);
    bus_if.ifmap_valid = 1'b1;
    bus_if.filt_valid  = 1'b1;
    bus_if.psum_ready  = 1'b1;
    @(negedge clk);
    check({v.name, " start-cycle outputs"}, longint'(strobes()), 0);
    @(posedge clk); #1;
    bus_if.start    = 1'b0;
    bus_if.filt_len = CNT_W'(1);
    bus_if.num_out  = CNT_W'(1);

    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      bus_if.start   = (cyc == v.mid_start);
      first_after_bp = 0;
      if (stall_left > 0) begin
        bus_if.filt_valid = 1'b0;
        stall_left--;
      end else if (!stall_done && v.stall_len > 0 && beats == v.stall_after) begin
        stall_done = 1;
        bus_if.filt_valid = 1'b0;
        stall_left = v.stall_len - 1;
      end else begin
        bus_if.filt_valid = 1'b1;
      end
      if (bp_left > 0) begin
        bus_if.psum_ready = 1'b0;
        in_bp = 1;
        bp_left--;
        if (bp_left == 0) pending_after = 1;
      end else if (!bp_done && v.bp_len > 0 && beats == v.bp_after) begin
        bp_done = 1;
        bus_if.psum_ready = 1'b0;
        in_bp = 1;
        bp_left = v.bp_len - 1;
        if (bp_left == 0) pending_after = 1;
      end else begin
        bus_if.psum_ready = 1'b1;
        in_bp = 0;
        if (pending_after) begin
          first_after_bp = 1;
          pending_after = 0;
        end
      end

      @(negedge clk);
      if (bus_if.ifmap_read_en) ifpops++;
      if (bus_if.filt_read_en) fpops++;
      if (bus_if.mac_en) begin
        if (bus_if.acc_clr) begin
          clrs++;
          if (beats < 32) clr_mask[beats] = 1'b1;
        end
        beats++;
      end
      if (bus_if.acc_clr && !bus_if.mac_en) anomalies++;
      if (bus_if.ifmap_read_en != bus_if.filt_read_en) anomalies++;
      if (bus_if.ifmap_read_en != bus_if.mac_en) anomalies++;
      if (bus_if.mac_en && !(bus_if.ifmap_valid && bus_if.filt_valid)) anomalies++;
      if (bus_if.psum_write_en && (!bus_if.psum_ready || bus_if.mac_en)) anomalies++;
      if (!bus_if.busy) anomalies++;
      if (bus_if.psum_write_en) writes++;
      if (in_bp && (bus_if.ifmap_read_en || bus_if.mac_en)) bp_reads++;
      if (first_after_bp) bp_push = bus_if.psum_write_en;
      if (bus_if.done) begin
        lat = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end

    check({v.name, " done latency"}, lat, v.exp_lat);
    check({v.name, " mac beats"}, beats, v.exp_beats);
    check({v.name, " ifmap pops"}, ifpops, v.exp_beats);
    check({v.name, " filt pops"}, fpops, v.exp_beats);
    check({v.name, " acc_clr count"}, clrs, v.exp_clrs);
    check({v.name, " acc_clr beat mask"}, longint'(clr_mask), longint'(v.exp_mask));
    check({v.name, " psum writes"}, writes, v.exp_writes);
    check({v.name, " strobe rule violations"}, anomalies, 0);
    if (v.bp_len > 0) begin
      check({v.name, " reads during backpressure"}, bp_reads, 0);
      check({v.name, " push when ready rises"}, bp_push, 1);
    end
  endtask

  task automatic reset_mid_job();
    bus_if.start       = 1'b1;
    bus_if.filt_len    = CNT_W'(5);
    bus_if.num_out     = CNT_W'(3);
    bus_if.ifmap_valid = 1'b1;
    bus_if.filt_valid  = 1'b1;
    bus_if.psum_ready  = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_mid: mac_en in second window", bus_if.mac_en, 1);
    #2 rst = 1'b1;
    #1;
    check("reset_mid: outputs cleared at once", longint'(strobes()), 0);
    @(posedge clk);
    @(negedge clk);
    check("reset_mid: outputs held in reset", longint'(strobes()), 0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{"stream",      3, 2, 0, 0, 0, 0, 0, 0,   6, 2, 32'h9,   2,   9};
    tbl[1] = '{"stall",       4, 1, 2, 2, 0, 0, 0, 0,   4, 1, 32'h1,   1,   8};
    tbl[2] = '{"backpress",   2, 2, 0, 0, 2, 3, 0, 0,   4, 2, 32'h5,   2,  10};
    tbl[3] = '{"zero_numout", 3, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0,   1};
    tbl[4] = '{"zero_filt",   0, 3, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0,   1};
    tbl[5] = '{"ign_start",   3, 2, 0, 0, 0, 0, 2, 0,   6, 2, 32'h9,   2,   9};
    tbl[6] = '{"filt1",       1, 3, 0, 0, 0, 0, 0, 0,   3, 3, 32'h7,   3,   7};
    tbl[7] = '{"after_reset", 5, 3, 0, 0, 0, 0, 0, 1,  15, 3, 32'h421, 3,  19};
    tbl[8] = '{"max_filt",  255, 1, 0, 0, 0, 0, 0, 0, 255, 1, 32'h1,   1, 257};

    rst                = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.filt_len    = '0;
    bus_if.num_out     = '0;
    bus_if.ifmap_valid = 1'b0;
    bus_if.filt_valid  = 1'b0;
    bus_if.psum_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_if.ifmap_valid = 1'b1;
    bus_if.filt_valid  = 1'b1;
    bus_if.psum_ready  = 1'b1;
    #1;
    check("reset: outputs zero", longint'(strobes()), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].pre_reset != 0) reset_mid_job();
      run_job(tbl[i]);
      $display("job %0d %s: fl=%0d no=%0d latency=%0d beats=%0d writes=%0d",
               i, tbl[i].name, tbl[i].fl, tbl[i].no, lat, beats, writes);
    end

    @(negedge clk);
    check("final: done pulse ended, idle", longint'(strobes()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
